// File: rtl/memory_board_ctrl.sv
// Board-side controller for the memory card game: owns symbols, face-up
// and matched flags and the current player; applies tracker results.
module memory_board_ctrl #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [3:0]  seed,
  input  logic [3:0]  cursor,
  input  logic        select_in,
  input  logic [1:0]  turn_status,
  input  logic        pair_in,
  input  logic [3:0]  sel_a,
  input  logic [3:0]  sel_b,
  output logic [3:0]  symbol_out,
  output logic        selectable,
  output logic        select_out,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  output logic        player,
  output logic        busy,
  output logic        game_over,
  output logic [1:0]  result
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    SHOW,
    OVER
  } state_t;

  state_t          state;
  logic [3:0]      sym [16];
  logic [CW-1:0]   cnt;
  logic [3:0]      lat_a;
  logic [3:0]      lat_b;
  logic            lat_pair;

  // Each symbol value lands on exactly two indices differing in bit 0.
  function automatic logic [3:0] deal(input logic [3:0] s,
                                      input logic [3:0] i);
    logic [3:0] x;
    x = i ^ s;
    return {1'b0, x[3:1]};
  endfunction

  assign symbol_out = sym[cursor];
  assign selectable = (state == PLAY)
                    & ~face_up[cursor]
                    & ~matched[cursor];
  assign select_out = select_in & selectable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b1;
      game_over <= 1'b0;
      result    <= 2'b00;
      face_up   <= '0;
      matched   <= '0;
      player    <= 1'b0;
      cnt       <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_pair  <= 1'b0;
      for (int i = 0; i < 16; i++) sym[i] <= '0;
    end else if (load) begin
      state     <= PLAY;
      busy      <= 1'b0;
      game_over <= 1'b0;
      result    <= 2'b00;
      face_up   <= '0;
      matched   <= '0;
      player    <= 1'b0;
      cnt       <= '0;
      for (int i = 0; i < 16; i++)
        sym[i] <= deal(seed, 4'(i));
    end else begin
      unique case (state)
        PLAY: begin
          if (turn_status[1]) begin
            state     <= OVER;
            busy      <= 1'b1;
            game_over <= 1'b1;
            result    <= turn_status;
            face_up   <= '0;
          end else begin
            if (select_out) face_up[cursor] <= 1'b1;
            if (turn_status == 2'b01) begin
              state    <= SHOW;
              busy     <= 1'b1;
              lat_a    <= sel_a;
              lat_b    <= sel_b;
              lat_pair <= pair_in;
              cnt      <= HOLD_LD;
            end
          end
        end
        SHOW: begin
          if (turn_status[1]) begin
            state     <= OVER;
            game_over <= 1'b1;
            result    <= turn_status;
            face_up   <= '0;
            cnt       <= '0;
          end else if (cnt == '0) begin
            state          <= PLAY;
            busy           <= 1'b0;
            face_up[lat_a] <= 1'b0;
            face_up[lat_b] <= 1'b0;
            if (lat_pair && (lat_a != lat_b)) begin
              matched[lat_a] <= 1'b1;
              matched[lat_b] <= 1'b1;
            end else begin
              player <= ~player;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        IDLE: ;
        OVER: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_board_ctrl.sv
// Scoreboard bench for memory_board_ctrl: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_memory_board_ctrl;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [3:0]  seed;
  logic [3:0]  cursor;
  logic        select_in;
  logic [1:0]  turn_status;
  logic        pair_in;
  logic [3:0]  sel_a;
  logic [3:0]  sel_b;
  logic [3:0]  symbol_out;
  logic        selectable;
  logic        select_out;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic        player;
  logic        busy;
  logic        game_over;
  logic [1:0]  result;

  memory_board_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .load(load), .seed(seed),
    .cursor(cursor), .select_in(select_in),
    .turn_status(turn_status), .pair_in(pair_in),
    .sel_a(sel_a), .sel_b(sel_b),
    .symbol_out(symbol_out), .selectable(selectable),
    .select_out(select_out), .face_up(face_up),
    .matched(matched), .player(player), .busy(busy),
    .game_over(game_over), .result(result)
  );

  always #5 clk = ~clk;

  typedef enum int {
    F_SYM, F_SELBL, F_SELO, F_FACE, F_MATCH,
    F_PLAYER, F_BUSY, F_OVER, F_RES
  } field_t;

  typedef struct {
    int          cyc;
    string       name;
    field_t      field;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pick(input field_t f);
    case (f)
      F_SYM:    return 16'(symbol_out);
      F_SELBL:  return 16'(selectable);
      F_SELO:   return 16'(select_out);
      F_FACE:   return face_up;
      F_MATCH:  return matched;
      F_PLAYER: return 16'(player);
      F_BUSY:   return 16'(busy);
      F_OVER:   return 16'(game_over);
      default:  return 16'(result);
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] act;
      e = sb.pop_front();
      checks++;
      act = pick(e.field);
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: stale expectation (cycle %0d)",
                 e.name, e.cyc);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)",
                 e.name, act, e.val, cyc);
      end
    end
  end

  task automatic ex(input string n, input field_t f,
                    input logic [15:0] v);
    exp_t e;
    e.cyc = cyc; e.name = n; e.field = f; e.val = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; load = 1'b0; seed = '0; cursor = '0;
    select_in = 1'b1; turn_status = 2'b00; pair_in = 1'b0;
    sel_a = '0; sel_b = '0;
    step();
    ex("rst_busy", F_BUSY, 1);
    ex("rst_over", F_OVER, 0);
    ex("rst_res", F_RES, 0);
    ex("rst_face", F_FACE, 0);
    ex("rst_match", F_MATCH, 0);
    ex("rst_player", F_PLAYER, 0);
    ex("rst_selbl", F_SELBL, 0);
    ex("rst_selo", F_SELO, 0);
    ex("rst_sym", F_SYM, 0);
    step(); rst = 1'b1; select_in = 1'b0;
    step();
    load = 1'b1; seed = 4'd0;
    step(); load = 1'b0;
    cursor = 4'd5;
    ex("load_busy", F_BUSY, 0);
    ex("load_player", F_PLAYER, 0);
    ex("sym5", F_SYM, 2);
    ex("selbl5", F_SELBL, 1);
    step(); cursor = 4'd4;  ex("sym4", F_SYM, 2);
    step(); cursor = 4'd15; ex("sym15", F_SYM, 7);

    // match turn on cards 2 and 3
    step(); cursor = 4'd2; select_in = 1'b1;
    ex("sel2", F_SELO, 1);
    step(); cursor = 4'd3;
    ex("sel3", F_SELO, 1);
    ex("face_2", F_FACE, 16'h0004);
    step(); select_in = 1'b0;
    ex("face_23", F_FACE, 16'h000C);
    turn_status = 2'b01; pair_in = 1'b1; sel_a = 4'd2; sel_b = 4'd3;
    ex("pre_show_busy", F_BUSY, 0);
    step(); turn_status = 2'b00;
    ex("show_busy1", F_BUSY, 1);
    step(); cursor = 4'd7; select_in = 1'b1;
    ex("show_busy2", F_BUSY, 1);
    ex("show_selo", F_SELO, 0);
    ex("show_selbl", F_SELBL, 0);
    step(); select_in = 1'b0;
    ex("show_busy3", F_BUSY, 1);
    ex("show_face", F_FACE, 16'h000C);
    step();
    ex("show_busy4", F_BUSY, 1);
    step(); cursor = 4'd2; select_in = 1'b1;
    ex("hit_busy", F_BUSY, 0);
    ex("hit_match", F_MATCH, 16'h000C);
    ex("hit_face", F_FACE, 0);
    ex("hit_player", F_PLAYER, 0);
    ex("matched_selo", F_SELO, 0);

    // mismatch turn on cards 0 and 5
    step(); cursor = 4'd0;
    ex("sel0", F_SELO, 1);
    step(); cursor = 4'd5;
    ex("sel5", F_SELO, 1);
    step(); cursor = 4'd0;
    ex("face_05", F_FACE, 16'h0021);
    ex("faceup_selo", F_SELO, 0);
    ex("faceup_selbl", F_SELBL, 0);
    step(); select_in = 1'b0;
    ex("faceup_keep", F_FACE, 16'h0021);
    turn_status = 2'b01; pair_in = 1'b0; sel_a = 4'd0; sel_b = 4'd5;
    step(); turn_status = 2'b00;
    ex("miss_busy1", F_BUSY, 1);
    step(); step(); step();
    ex("miss_busy4", F_BUSY, 1);
    step();
    ex("miss_busy", F_BUSY, 0);
    ex("miss_face", F_FACE, 0);
    ex("miss_match", F_MATCH, 16'h000C);
    ex("miss_player", F_PLAYER, 1);

    // winner arriving mid-SHOW
    cursor = 4'd1; select_in = 1'b1;
    ex("sel1", F_SELO, 1);
    step(); select_in = 1'b0;
    ex("face_1", F_FACE, 16'h0002);
    turn_status = 2'b01; pair_in = 1'b0; sel_a = 4'd1; sel_b = 4'd6;
    step(); turn_status = 2'b00;
    ex("w_show", F_BUSY, 1);
    step(); turn_status = 2'b10;
    ex("w_pre_over", F_OVER, 0);
    step(); turn_status = 2'b00;
    ex("w_over", F_OVER, 1);
    ex("w_res", F_RES, 2'b10);
    ex("w_face", F_FACE, 0);
    ex("w_player", F_PLAYER, 1);
    ex("w_match", F_MATCH, 16'h000C);
    ex("w_busy", F_BUSY, 1);
    step(); step();
    ex("w_hold", F_OVER, 1);
    ex("w_hold_busy", F_BUSY, 1);
    load = 1'b1; seed = 4'd3; turn_status = 2'b11;
    step(); load = 1'b0; turn_status = 2'b00; cursor = 4'd0;
    ex("rl_busy", F_BUSY, 0);
    ex("rl_res", F_RES, 0);
    ex("rl_over", F_OVER, 0);
    ex("rl_player", F_PLAYER, 0);
    ex("rl_match", F_MATCH, 0);
    ex("rl_sym0", F_SYM, 1);

    // reset during SHOW
    select_in = 1'b1;
    step(); select_in = 1'b0;
    turn_status = 2'b01; pair_in = 1'b0; sel_a = 4'd0; sel_b = 4'd0;
    ex("r_face", F_FACE, 16'h0001);
    step(); turn_status = 2'b00;
    ex("r_show", F_BUSY, 1);
    #2 rst = 1'b0;
    #1;
    ex("r_face0", F_FACE, 0);
    ex("r_sym0", F_SYM, 0);
    ex("r_selbl", F_SELBL, 0);
    ex("r_busy", F_BUSY, 1);
    step(); rst = 1'b1; select_in = 1'b1;
    ex("r_idle_selo", F_SELO, 0);
    ex("r_idle_selbl", F_SELBL, 0);
    step(); select_in = 1'b0;
    ex("r_idle_face", F_FACE, 0);
    ex("r_idle_busy", F_BUSY, 1);
    step(); step();
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations never checked, required 0",
               sb.size());
      errors += sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
